// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: drives the register-file write port from the ALU and a FIFO of external results.
// Define CORE_WB_BYPASS_EN to enable the same-cycle read bypass outputs.
package config_pkg;
    typedef struct packed {
        int unsigned xlen;
        logic        e_supported;
    } config_t;
    localparam config_t DEFAULT_CONF = '{xlen: 32, e_supported: 1'b0};
endpackage

module core_wb_arbiter
    import config_pkg::*;
#(
    parameter config_t CONF  = DEFAULT_CONF,
    parameter int      DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [CONF.xlen-1:0]     alu_data,
    input  logic                     ext_valid,
    output logic                     ext_ready,
    input  logic [4:0]               ext_rd,
    input  logic [CONF.xlen-1:0]     ext_data,
    output logic [4:0]               rf_a2,
    output logic [CONF.xlen-1:0]     rf_wd2,
    output logic                     rf_we2,
    input  logic [4:0]               byp_a0,
    input  logic [4:0]               byp_a1,
    output logic                     byp_hit0,
    output logic                     byp_hit1,
    output logic [CONF.xlen-1:0]     byp_data0,
    output logic [CONF.xlen-1:0]     byp_data1,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int XLEN = CONF.xlen;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [AW-1:0]   head, tail;
    logic            ext_fire, alu_w, ext_w, pop, direct, push, wr;
    logic [31:0]     pop_bit, push_bit;

    // x0 is hardwired and x16..x31 do not exist in E mode: such results are swallowed
    function automatic logic is_null(input logic [4:0] rd);
        return rd == 5'd0 || (CONF.e_supported && rd[4]);
    endfunction

    assign ext_ready = fifo_count != FULL;
    assign ext_fire  = ext_valid && ext_ready;
    assign alu_w     = alu_valid && !is_null(alu_rd);
    assign ext_w     = ext_fire && !is_null(ext_rd);
    assign pop       = !alu_w && fifo_count != '0;
    assign direct    = !alu_w && fifo_count == '0 && ext_w;
    assign push      = ext_w && !direct;
    assign wr        = alu_w || pop || direct;
    assign pop_bit   = pop ? 32'd1 << q_rd[head] : 32'd0;
    assign push_bit  = push ? 32'd1 << ext_rd : 32'd0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rf_we2       <= 1'b0;
            rf_a2        <= '0;
            rf_wd2       <= '0;
            head         <= '0;
            tail         <= '0;
            fifo_count   <= '0;
            pending_mask <= '0;
        end else begin
            rf_we2 <= wr;
            if (wr) begin
                rf_a2  <= alu_w ? alu_rd : pop ? q_rd[head] : ext_rd;
                rf_wd2 <= alu_w ? alu_data : pop ? q_data[head] : ext_data;
            end
            if (pop) head <= head + AW'(1);
            if (push) tail <= tail + AW'(1);
            fifo_count   <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            pending_mask <= (pending_mask & ~pop_bit) | push_bit;
        end

    always_ff @(posedge clk)
        if (push) begin
            q_rd[tail]   <= ext_rd;
            q_data[tail] <= ext_data;
        end

    // the issue stage must never queue two results for the same register
    assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (!pending_mask[ext_rd] || (pop && q_rd[head] == ext_rd)));

`ifdef CORE_WB_BYPASS_EN
    assign byp_hit0  = rf_we2 && rf_a2 == byp_a0 && byp_a0 != 5'd0;
    assign byp_hit1  = rf_we2 && rf_a2 == byp_a1 && byp_a1 != 5'd0;
    assign byp_data0 = byp_hit0 ? rf_wd2 : '0;
    assign byp_data1 = byp_hit1 ? rf_wd2 : '0;
`else
    logic unused_byp;
    assign unused_byp = ^{byp_a0, byp_a1};
    assign byp_hit0   = 1'b0;
    assign byp_hit1   = 1'b0;
    assign byp_data0  = '0;
    assign byp_data1  = '0;
`endif
endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb_core_wb_arbiter: directed and random checks of core_wb_arbiter against a queue model.
// Instance 0 uses the default config, instance 1 enables E mode.
module tb_core_wb_arbiter;
    import config_pkg::*;
    localparam int DEPTH = 4;
    localparam config_t C1 = '{xlen: 32, e_supported: 1'b1};

    logic        clk, rst_n;
    logic        av [2], ev [2], ready [2], we2 [2], hit0 [2], hit1 [2];
    logic [4:0]  ar [2], er [2], a2 [2];
    logic [31:0] ad [2], ed [2], wd2 [2], bd0 [2], bd1 [2], mask [2];
    logic [2:0]  cnt [2];
    logic [4:0]  ba0, ba1;
    int          n = 0, err = 0;

    // reference model: queued results plus the write expected on the port
    logic [4:0]  qr [2][DEPTH];
    logic [31:0] qd [2][DEPTH];
    int          qn [2];
    bit          mwe [2], acc [2];
    bit [4:0]    ma [2];
    bit [31:0]   mwd [2];

    core_wb_arbiter #(.DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .alu_valid(av[0]), .alu_rd(ar[0]), .alu_data(ad[0]),
        .ext_valid(ev[0]), .ext_ready(ready[0]), .ext_rd(er[0]), .ext_data(ed[0]),
        .rf_a2(a2[0]), .rf_wd2(wd2[0]), .rf_we2(we2[0]), .byp_a0(ba0), .byp_a1(ba1),
        .byp_hit0(hit0[0]), .byp_hit1(hit1[0]), .byp_data0(bd0[0]), .byp_data1(bd1[0]),
        .pending_mask(mask[0]), .fifo_count(cnt[0]));

    core_wb_arbiter #(.CONF(C1), .DEPTH(DEPTH)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .alu_valid(av[1]), .alu_rd(ar[1]), .alu_data(ad[1]),
        .ext_valid(ev[1]), .ext_ready(ready[1]), .ext_rd(er[1]), .ext_data(ed[1]),
        .rf_a2(a2[1]), .rf_wd2(wd2[1]), .rf_we2(we2[1]), .byp_a0(ba0), .byp_a1(ba1),
        .byp_hit0(hit0[1]), .byp_hit1(hit1[1]), .byp_data0(bd0[1]), .byp_data1(bd1[1]),
        .pending_mask(mask[1]), .fifo_count(cnt[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    function automatic bit is_null(input int i, input logic [4:0] rd);
        return rd == 5'd0 || (i == 1 && rd[4]);
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        logic [31:0] m = '0;
        for (int j = 0; j < qn[i]; j++) m[qr[i][j]] = 1'b1;
        return m;
    endfunction

    function automatic bit in_q(input int i, input logic [4:0] rd);
        for (int j = 0; j < qn[i]; j++) if (qr[i][j] == rd) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4:0] fresh_rd(input int i);
        logic [4:0] r;
        for (int t = 0; t < 64; t++) begin
            r = 5'($urandom_range(0, 31));
            if (!in_q(i, r)) return r;
        end
        return 5'd0;
    endfunction

    // model: ALU first, then oldest queued result, then a direct external result
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            bit fire, aw, ew;
            if (!rst_n) begin
                qn[i] = 0; mwe[i] = 0; ma[i] = 0; mwd[i] = 0; acc[i] = 0;
                continue;
            end
            fire   = ev[i] && qn[i] != DEPTH;
            acc[i] = fire;
            aw     = av[i] && !is_null(i, ar[i]);
            ew     = fire && !is_null(i, er[i]);
            mwe[i] = 1'b1;
            if (aw) begin
                ma[i] = ar[i]; mwd[i] = ad[i];
            end else if (qn[i] > 0) begin
                ma[i] = qr[i][0]; mwd[i] = qd[i][0];
                for (int j = 1; j < qn[i]; j++) begin qr[i][j-1] = qr[i][j]; qd[i][j-1] = qd[i][j]; end
                qn[i]--;
            end else if (ew) begin
                ma[i] = er[i]; mwd[i] = ed[i]; ew = 0;
            end else mwe[i] = 1'b0;
            if (ew) begin qr[i][qn[i]] = er[i]; qd[i][qn[i]] = ed[i]; qn[i]++; end
        end
    end

    initial forever begin
        bit eh0, eh1;
        @(negedge clk);
        if (rst_n) for (int i = 0; i < 2; i++) begin
`ifdef CORE_WB_BYPASS_EN
            eh0 = mwe[i] && ma[i] == ba0 && ba0 != 0;
            eh1 = mwe[i] && ma[i] == ba1 && ba1 != 0;
`else
            eh0 = 0;
            eh1 = 0;
`endif
            chk("rf_we2", i, 64'(we2[i]), 64'(mwe[i]));
            if (mwe[i]) begin
                chk("rf_a2", i, 64'(a2[i]), 64'(ma[i]));
                chk("rf_wd2", i, 64'(wd2[i]), 64'(mwd[i]));
            end
            chk("fifo_count", i, 64'(cnt[i]), 64'(qn[i]));
            chk("pending_mask", i, 64'(mask[i]), 64'(mask_of(i)));
            chk("ext_ready", i, 64'(ready[i]), 64'(qn[i] != DEPTH));
            chk("byp_hit0", i, 64'(hit0[i]), 64'(eh0));
            chk("byp_hit1", i, 64'(hit1[i]), 64'(eh1));
            chk("byp_data0", i, 64'(bd0[i]), eh0 ? 64'(mwd[i]) : 64'd0);
            chk("byp_data1", i, 64'(bd1[i]), eh1 ? 64'(mwd[i]) : 64'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            av[i] = 0; ar[i] = 0; ad[i] = 0; ev[i] = 0; er[i] = 0; ed[i] = 0;
        end
        ba0 = 0; ba1 = 0;
    endtask

    task automatic chk_reset(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_we"}, i, 64'(we2[i]), 64'd0);
            chk({nm, "_a2"}, i, 64'(a2[i]), 64'd0);
            chk({nm, "_wd2"}, i, 64'(wd2[i]), 64'd0);
            chk({nm, "_cnt"}, i, 64'(cnt[i]), 64'd0);
            chk({nm, "_mask"}, i, 64'(mask[i]), 64'd0);
            chk({nm, "_ready"}, i, 64'(ready[i]), 64'd1);
            chk({nm, "_hit0"}, i, 64'(hit0[i]), 64'd0);
            chk({nm, "_data1"}, i, 64'(bd1[i]), 64'd0);
        end
    endtask

    initial begin
        int pct [6] = '{80, 30, 0, 95, 50, 100};
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        av[0] = 1; ar[0] = 5; ad[0] = 32'hDEADBEEF;
        tick();
        chk("alu_we", 0, 64'(we2[0]), 64'd1);
        chk("alu_a2", 0, 64'(a2[0]), 64'd5);
        chk("alu_wd2", 0, 64'(wd2[0]), 64'hDEADBEEF);
        ar[0] = 0;
        tick();
        chk("alu_x0_we", 0, 64'(we2[0]), 64'd0);

        av[0] = 0; ev[0] = 1; er[0] = 7; ed[0] = 32'h11;
        tick();
        ev[0] = 0;
        chk("ext_direct_we", 0, 64'(we2[0]), 64'd1);
        chk("ext_direct_a2", 0, 64'(a2[0]), 64'd7);
        chk("ext_direct_wd2", 0, 64'(wd2[0]), 64'h11);
        chk("ext_direct_cnt", 0, 64'(cnt[0]), 64'd0);

        for (int k = 0; k < 6; k++) begin
            av[0] = 1; ar[0] = 1; ad[0] = k;
            ev[0] = 1; er[0] = 5'(8 + (k < 4 ? k : 4)); ed[0] = 100 + er[0];
            tick();
        end
        chk("full_cnt", 0, 64'(cnt[0]), 64'd4);
        chk("full_ready", 0, 64'(ready[0]), 64'd0);
        chk("full_mask", 0, 64'(mask[0]), 64'h0F00);
        chk("full_a2", 0, 64'(a2[0]), 64'd1);
        av[0] = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("drain_we", 0, 64'(we2[0]), 64'd1);
            chk("drain_a2", 0, 64'(a2[0]), 64'(8 + j));
            chk("drain_wd2", 0, 64'(wd2[0]), 64'(108 + j));
            if (j == 1) begin
                chk("pushpop_cnt", 0, 64'(cnt[0]), 64'd3);
                ev[0] = 0;
            end
        end
        tick();
        chk("drained_cnt", 0, 64'(cnt[0]), 64'd0);

        for (int k = 0; k < 3; k++) begin
            av[0] = 1; ar[0] = 2; ad[0] = k;
            ev[0] = 1; er[0] = 5'(13 + k); ed[0] = k;
            tick();
        end
        chk("pre_rst_cnt", 0, 64'(cnt[0]), 64'd3);
        chk("pre_rst_mask", 0, 64'(mask[0]), 64'hE000);
        idle();
        #1 rst_n = 1'b0;
        #1 chk_reset("midrst");
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_we", 0, 64'(we2[0]), 64'd0);
        end

        ev[1] = 1; er[1] = 20; ed[1] = 5;
        ev[0] = 1; er[0] = 20; ed[0] = 6;
        chk("e_ready", 1, 64'(ready[1]), 64'd1);
        tick();
        ev[0] = 0; ev[1] = 0;
        chk("e_drop_we", 1, 64'(we2[1]), 64'd0);
        chk("e_drop_mask", 1, 64'(mask[1]), 64'd0);
        chk("e_drop_cnt", 1, 64'(cnt[1]), 64'd0);
        chk("noe_we", 0, 64'(we2[0]), 64'd1);
        chk("noe_a2", 0, 64'(a2[0]), 64'd20);

        av[0] = 1; ar[0] = 3; ad[0] = 32'hCAFE;
        tick();
        av[0] = 0; ba0 = 3; ba1 = 4;
        #1;
`ifdef CORE_WB_BYPASS_EN
        chk("byp_hit0_lit", 0, 64'(hit0[0]), 64'd1);
        chk("byp_data0_lit", 0, 64'(bd0[0]), 64'hCAFE);
`else
        chk("byp_hit0_lit", 0, 64'(hit0[0]), 64'd0);
        chk("byp_data0_lit", 0, 64'(bd0[0]), 64'd0);
`endif
        chk("byp_hit1_lit", 0, 64'(hit1[0]), 64'd0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(ev[i] && !acc[i])) begin
                    ev[i] = $urandom_range(0, 99) < 60;
                    er[i] = fresh_rd(i);
                    ed[i] = $urandom;
                end
                av[i] = $urandom_range(0, 99) < pct[c / 500];
                ar[i] = 5'($urandom_range(0, 31));
                ad[i] = $urandom;
            end
            ba0 = $urandom_range(0, 1) ? ma[0] : 5'($urandom_range(0, 31));
            ba1 = $urandom_range(0, 1) ? ma[1] : 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        repeat (10) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n, err);
        $finish;
    end
endmodule
